// File: rtl/vec_mag_iter.sv
// Iterative vector magnitude: mag_out = sqrt(x^2 + y^2) via a bit-serial integer square root.
// Optional round-to-nearest stage enabled by defining VEC_MAG_ROUND_EN.
module vec_mag_iter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   mag_out,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        SQUARE,
        ROOT,
        DONE
`ifdef VEC_MAG_ROUND_EN
        , ROUND
`endif
    } state_t;

    state_t         state;
    logic [W-1:0]   x_r;
    logic [W-1:0]   y_r;
    logic [2*W+1:0] s_sh;
    logic [W+3:0]   rem;
    logic [W:0]     root;
    logic [4:0]     cnt;

    logic [2*W:0]   sq;
    logic [W+3:0]   rem_sh;
    logic [W+3:0]   trial;
    logic [W+3:0]   rem_nx;
    logic [W:0]     root_nx;

    assign in_ready = rst_n & ena & (state == IDLE);
    assign busy     = (state != IDLE);

    // One restoring step: bring down the next two radicand bits, try (4r+1).
    always_comb begin
        sq      = (2*W+1)'(x_r) * (2*W+1)'(x_r) + (2*W+1)'(y_r) * (2*W+1)'(y_r);
        rem_sh  = (rem << 2) | (W+4)'(s_sh[2*W+1 -: 2]);
        trial   = (W+4)'({root, 2'b01});
        rem_nx  = rem_sh;
        root_nx = {root[W-1:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh - trial;
            root_nx = {root[W-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            s_sh      <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            mag_out   <= '0;
            out_valid <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r   <= x_in;
                        y_r   <= y_in;
                        state <= SQUARE;
                    end
                end
                SQUARE: begin
                    s_sh  <= {1'b0, sq};
                    rem   <= '0;
                    root  <= '0;
                    cnt   <= 5'(W);
                    state <= ROOT;
                end
                ROOT: begin
                    s_sh <= s_sh << 2;
                    rem  <= rem_nx;
                    root <= root_nx;
                    cnt  <= cnt - 5'd1;
                    if (cnt == '0) begin
`ifdef VEC_MAG_ROUND_EN
                        state <= ROUND;
`else
                        mag_out   <= root_nx;
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
`ifdef VEC_MAG_ROUND_EN
                ROUND: begin
                    mag_out   <= (rem > (W+4)'(root)) ? root + (W+1)'(1) : root;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mag_iter.sv
// Directed self-checking bench for vec_mag_iter (W=8); expectations follow VEC_MAG_ROUND_EN.
module tb_vec_mag_iter;

    localparam int W = 8;
`ifdef VEC_MAG_ROUND_EN
    localparam int LAT = W + 3;
`else
    localparam int LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   mag_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    vec_mag_iter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready), .mag_out(mag_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int mag_floor;
        int mag_round;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_mag(input int x, input int y);
        int s;
        int r;
        s = x * x + y * y;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
`ifdef VEC_MAG_ROUND_EN
        if (s - r * r > r) r++;
`endif
        return r;
    endfunction

    // Offer one pair, optionally dropping ena for frz_len edges after edge frz_at.
    task automatic run_pair(input int x, input int y, input int frz_at, input int frz_len,
                            output int mag, output int lat);
        int t;
        @(negedge clk);
        x_in = W'(x);
        y_in = W'(y);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in = W'($urandom);
        y_in = W'($urandom);
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            ena = !(k > frz_at && k <= frz_at + frz_len);
            if (!ena) chk("in_ready_ena_low", int'(in_ready), 0);
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        ena = 1'b1;
        mag = int'(mag_out);
    endtask

    vec_t vecs[10];
    int   mag;
    int   lat;
    int   exp_mag;
    int   seen;
    int   cap_q[$];
    int   res_q[$];

    initial begin
        vecs[0] = '{3, 4, 5, 5};
        vecs[1] = '{255, 255, 360, 361};
        vecs[2] = '{2, 3, 3, 4};
        vecs[3] = '{0, 0, 0, 0};
        vecs[4] = '{6, 8, 10, 10};
        vecs[5] = '{1, 1, 1, 1};
        vecs[6] = '{255, 0, 255, 255};
        vecs[7] = '{5, 12, 13, 13};
        vecs[8] = '{7, 7, 9, 10};
        vecs[9] = '{100, 200, 223, 224};

        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x_in = '0; y_in = '0;
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_mag", int'(mag_out), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++) begin
`ifdef VEC_MAG_ROUND_EN
            exp_mag = vecs[i].mag_round;
`else
            exp_mag = vecs[i].mag_floor;
`endif
            run_pair(vecs[i].x, vecs[i].y, 1000, 0, mag, lat);
            chk($sformatf("vec%0d_mag", i), mag, exp_mag);
            chk($sformatf("vec%0d_lat", i), lat, LAT);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_drain", i), int'(out_valid), 0);
        end

        // Consumer stalls in DONE.
        out_ready = 1'b0;
        run_pair(3, 4, 1000, 0, mag, lat);
        chk("stall_lat", lat, LAT);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_mag", int'(mag_out), 5);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", int'(out_valid), 0);
        chk("stall_release_in_ready", int'(in_ready), 1);
        chk("stall_release_busy", int'(busy), 0);
        chk("stall_mag_kept", int'(mag_out), 5);

        // ena dropped for 4 edges while in ROOT.
        run_pair(7, 7, 4, 4, mag, lat);
        chk("freeze_mag", mag, ref_mag(7, 7));
        chk("freeze_lat", lat, LAT + 4);
        @(posedge clk);
        #1;

        // Reset during ROOT abandons the computation.
        @(negedge clk);
        x_in = 8'd100; y_in = 8'd200; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_mag", int'(mag_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);
        run_pair(6, 8, 1000, 0, mag, lat);
        chk("midrst_next_mag", mag, 10);
        chk("midrst_next_lat", lat, LAT);
        @(posedge clk);
        #1;

        // in_valid held high with operands changing every cycle.
        in_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            x_in = W'($urandom_range(0, 255));
            y_in = W'($urandom_range(0, 255));
            if (in_ready) cap_q.push_back(ref_mag(int'(x_in), int'(y_in)));
            @(posedge clk);
            #1;
            if (out_valid) res_q.push_back(int'(mag_out));
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) res_q.push_back(int'(mag_out));
        end
        chk("stream_count", res_q.size(), cap_q.size());
        chk("stream_nonempty", int'(cap_q.size() >= 4), 1);
        for (int i = 0; i < cap_q.size() && i < res_q.size(); i++)
            chk($sformatf("stream%0d_mag", i), res_q[i], cap_q[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
